// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
// pid_pkg -- shared widths, PWM state type and magnitude helper
// Rev 1.0
// ============================================================================
package pid_pkg;

    localparam int DUTY_W = 5;
    localparam int U_W    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } pwm_state_t;

    // |u| for a two's complement word; the single value with no positive
    // counterpart (-32) saturates to the largest duty.
    function automatic logic [DUTY_W-1:0] sat_mag(input logic [U_W-1:0] u);
        logic [U_W-1:0] neg;
        neg = ~u + U_W'(1);
        if (!u[U_W-1]) begin
            return u[DUTY_W-1:0];
        end else if (neg[U_W-1]) begin
            return '1;
        end else begin
            return neg[DUTY_W-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/pid_pwm_driver_if.sv
`default_nettype none
// ============================================================================
// pid_pwm_driver_if -- control word input and sign/magnitude PWM outputs
// Rev 1.0
// ============================================================================
interface pid_pwm_driver_if;
    import pid_pkg::*;

    logic              ena;
    logic [U_W-1:0]    u;
    logic              u_valid;
    logic              pwm;
    logic              dir;
    logic [DUTY_W-1:0] duty;
    logic              period_start;

    modport master (
        output ena, u, u_valid,
        input  pwm, dir, duty, period_start
    );

    modport slave (
        input  ena, u, u_valid,
        output pwm, dir, duty, period_start
    );

endinterface
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// tick_gen -- free-running prescaler, one tick every PRESCALE clocks
// Rev 1.0
// ============================================================================
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr_i,
    output logic      tick_o
);

    localparam int              PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] c_PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    always_comb begin
        pre_d = pre_q;
        if (clr_i || (pre_q == c_PRE_MAX)) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    assign tick_o = !clr_i && (pre_q == c_PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pid_pwm_driver.sv
`default_nettype none
// ============================================================================
// pid_pwm_driver -- double-buffered sign/magnitude PWM with reversal dead time
// Rev 1.0
// ============================================================================
module pid_pwm_driver
    import pid_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int DEAD_T   = 2,
    parameter int DEADBAND = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pid_pwm_driver_if.slave   bus
);

    localparam logic [DUTY_W-1:0] c_DEADBAND  = DUTY_W'(DEADBAND);
    localparam logic [DUTY_W-1:0] c_DEAD_LAST = DUTY_W'(DEAD_T - 1);

    pwm_state_t        state_q,    state_d;
    logic [DUTY_W-1:0] cnt_q,      cnt_d;
    logic [DUTY_W-1:0] duty_q,     duty_d;
    logic              dir_q,      dir_d;
    logic [U_W-1:0]    pend_q,     pend_d;
    logic [DUTY_W-1:0] lat_mag_q,  lat_mag_d;
    logic              lat_sign_q, lat_sign_d;
    logic              ps_q,       ps_d;

    logic              w_tick;
    logic              w_pre_clr;
    logic              w_load;
    logic [DUTY_W-1:0] w_mag_raw;
    logic [DUTY_W-1:0] w_mag;
    logic              w_sign;

    assign w_pre_clr = (state_q == IDLE) || !bus.ena;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_pre_clr),
        .tick_o (w_tick)
    );

    assign w_mag_raw = sat_mag(pend_q);
    assign w_mag     = (w_mag_raw <= c_DEADBAND) ? '0 : w_mag_raw;
    assign w_sign    = pend_q[U_W-1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        lat_mag_d  = lat_mag_q;
        lat_sign_d = lat_sign_q;
        ps_d       = 1'b0;
        w_load     = 1'b0;

        if (bus.ena && bus.u_valid) begin
            pend_d = bus.u;
        end

        if (!bus.ena) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    w_load = 1'b1;
                end
                RUN: begin
                    if (w_tick) begin
                        if (cnt_q == '1) begin
                            w_load = 1'b1;
                        end else begin
                            cnt_d = cnt_q + DUTY_W'(1);
                        end
                    end
                end
                DEAD: begin
                    if (w_tick) begin
                        if (cnt_q == c_DEAD_LAST) begin
                            state_d = RUN;
                            cnt_d   = '0;
                            duty_d  = lat_mag_q;
                            dir_d   = lat_sign_q;
                            ps_d    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + DUTY_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Boundary load: a nonzero opposite-sign request must pass through DEAD
        // so both bridge legs are off before the direction flips.
        if (w_load) begin
            cnt_d = '0;
            if ((w_mag != '0) && (w_sign != dir_q)) begin
                state_d    = DEAD;
                duty_d     = '0;
                lat_mag_d  = w_mag;
                lat_sign_d = w_sign;
            end else begin
                state_d = RUN;
                duty_d  = w_mag;
                ps_d    = 1'b1;
                if (w_mag != '0) begin
                    dir_d = w_sign;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            duty_q     <= '0;
            dir_q      <= 1'b0;
            pend_q     <= '0;
            lat_mag_q  <= '0;
            lat_sign_q <= 1'b0;
            ps_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            lat_mag_q  <= lat_mag_d;
            lat_sign_q <= lat_sign_d;
            ps_q       <= ps_d;
        end
    end

    assign bus.pwm          = (state_q == RUN) && (cnt_q < duty_q);
    assign bus.dir          = dir_q;
    assign bus.duty         = duty_q;
    assign bus.period_start = ps_q;

endmodule
`default_nettype wire

// File: tb/tb_pid_pwm_driver.sv
`default_nettype none
// ============================================================================
// tb_pid_pwm_driver -- directed self-checking bench, PRESCALE=1 DEAD_T=2 DEADBAND=1
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pid_pwm_driver;
    import pid_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    pid_pwm_driver_if bus();

    pid_pwm_driver #(
        .PRESCALE (1),
        .DEAD_T   (2),
        .DEADBAND (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From a period_start sample, count pwm-high samples until the next period_start.
    task automatic measure(output int highs, output int len);
        highs = 0;
        len   = 0;
        do begin
            highs += int'(bus.pwm);
            len++;
            step();
        end while (bus.period_start !== 1'b1 && len < 64);
    endtask

    task automatic to_boundary(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.period_start !== 1'b1 && n < 64);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int h;
        int l;
        int n;

        bus.ena     = 1'b0;
        bus.u       = '0;
        bus.u_valid = 1'b0;
        step();
        step();
        check_eq("rst_pwm",  bus.pwm,          0);
        check_eq("rst_dir",  bus.dir,          0);
        check_eq("rst_duty", bus.duty,         0);
        check_eq("rst_ps",   bus.period_start, 0);
        rst = 1'b0;
        step();
        step();
        check_eq("idle_pwm", bus.pwm,          0);
        check_eq("idle_ps",  bus.period_start, 0);

        // Enable with +16; entry loads the old pending value (0)
        bus.ena = 1'b1; bus.u = 6'd16; bus.u_valid = 1'b1;
        step();
        bus.u_valid = 1'b0;
        check_eq("en_ps",   bus.period_start, 1);
        check_eq("en_duty", bus.duty,         0);
        measure(h, l);
        check_eq("p0_len",  l, 32);
        check_eq("p0_high", h, 0);
        check_eq("pos_duty", bus.duty, 16);
        check_eq("pos_dir",  bus.dir,  0);
        measure(h, l);
        check_eq("pos_len",  l, 32);
        check_eq("pos_high", h, 16);

        // Last write wins: +8 then +20 mid-period
        repeat (5) step();
        bus.u = 6'd8; bus.u_valid = 1'b1;
        step();
        bus.u_valid = 1'b0;
        repeat (5) step();
        bus.u = 6'd20; bus.u_valid = 1'b1;
        step();
        bus.u_valid = 1'b0;
        to_boundary(n);
        check_eq("lww_clks", n, 20);
        check_eq("lww_duty", bus.duty, 20);

        // u_valid on the boundary clk: old pending loads, new one next period
        repeat (31) step();
        bus.u = 6'd4; bus.u_valid = 1'b1;
        step();
        bus.u_valid = 1'b0;
        check_eq("coll_ps",   bus.period_start, 1);
        check_eq("coll_duty", bus.duty,         20);
        measure(h, l);
        check_eq("coll_len",   l, 32);
        check_eq("coll_high",  h, 20);
        check_eq("coll_duty2", bus.duty, 4);

        // Deadband: +1 and -1 both map to zero, no direction change
        bus.u = 6'd1; bus.u_valid = 1'b1;
        measure(h, l);
        check_eq("db_p_high", h, 4);
        check_eq("db_p_duty", bus.duty, 0);
        check_eq("db_p_dir",  bus.dir,  0);
        bus.u = 6'h3F;
        measure(h, l);
        bus.u_valid = 1'b0;
        check_eq("db_n_duty", bus.duty, 0);
        check_eq("db_n_dir",  bus.dir,  0);
        measure(h, l);
        check_eq("db_n_len",  l, 32);
        check_eq("db_n_high", h, 0);

        // Reversal from +16 to -32 (saturates to 31) via 2 dead ticks
        bus.u = 6'd16; bus.u_valid = 1'b1;
        measure(h, l);
        check_eq("rv_pre_duty", bus.duty, 16);
        bus.u = 6'h20;
        measure(h, l);
        bus.u_valid = 1'b0;
        check_eq("rv_len",  l, 34);
        check_eq("rv_high", h, 16);
        check_eq("rv_dir",  bus.dir,  1);
        check_eq("rv_duty", bus.duty, 31);
        measure(h, l);
        check_eq("sat_len",  l, 32);
        check_eq("sat_high", h, 31);

        // Enable drop during RUN, then re-enable
        repeat (3) step();
        check_eq("drun_pre_pwm", bus.pwm, 1);
        bus.ena = 1'b0;
        step();
        check_eq("drun_pwm",  bus.pwm,  0);
        check_eq("drun_duty", bus.duty, 31);
        check_eq("drun_dir",  bus.dir,  1);
        repeat (3) step();
        check_eq("drun_ps",   bus.period_start, 0);
        bus.ena = 1'b1;
        step();
        check_eq("reen_ps",  bus.period_start, 1);
        check_eq("reen_pwm", bus.pwm,          1);

        // Enable drop during DEAD
        bus.u = 6'd8; bus.u_valid = 1'b1;
        step();
        bus.u_valid = 1'b0;
        repeat (31) step();
        check_eq("dead_pwm",  bus.pwm,  0);
        check_eq("dead_duty", bus.duty, 0);
        check_eq("dead_dir",  bus.dir,  1);
        bus.ena = 1'b0;
        step();
        check_eq("ddrop_pwm", bus.pwm,          0);
        check_eq("ddrop_dir", bus.dir,          1);
        check_eq("ddrop_ps",  bus.period_start, 0);
        step();
        bus.ena = 1'b1;
        to_boundary(n);
        check_eq("ddrop_reen_found", (n < 64), 1);
        check_eq("ddrop_reen_duty",  bus.duty, 8);
        check_eq("ddrop_reen_dir",   bus.dir,  0);

        // Asynchronous reset mid-pulse
        repeat (2) step();
        check_eq("mid_pre_pwm", bus.pwm, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_pwm",  bus.pwm,  0);
        check_eq("arst_dir",  bus.dir,  0);
        check_eq("arst_duty", bus.duty, 0);
        bus.ena = 1'b0;
        step();
        rst = 1'b0;
        repeat (4) step();
        check_eq("post_rst_pwm", bus.pwm,          0);
        check_eq("post_rst_ps",  bus.period_start, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pid_pwm_driver.md
# pid_pwm_driver

Output stage directly downstream of the PID sum: takes the signed 6-bit control word `u` and drives a sign/magnitude PWM pair (`pwm`, `dir`) for an H-bridge. New values are double-buffered and applied only at PWM period boundaries, so a pulse is never cut or stretched mid-period. A configurable dead time is inserted on every direction reversal, and a small deadband around zero suppresses chatter.

## Interface
Parameters:
- `PRESCALE`, default 1: clk cycles per PWM tick, range 1..256.
- `DEAD_T`, default 2: PWM ticks with `pwm` forced low on a direction reversal, range 1..31.
- `DEADBAND`, default 1: magnitudes at or below this value map to duty 0, range 0..31.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ena` in 1: block enable; low forces the IDLE state.
- `u` in 6: control word, two's complement, range -32..31.
- `u_valid` in 1: `u` is captured into the pending register this cycle.
- `pwm` out 1: PWM pulse.
- `dir` out 1: direction; 0 = positive, 1 = negative.
- `duty` out 5: active duty, 0..31, in ticks out of 32.
- `period_start` out 1: one-clk strobe when the period counter loads 0.

## Operation
- Pending capture: when `u_valid` and `ena` are high, `u` goes into the pending register. Last write wins. The pending register holds its value while `ena` is low.
- Conversion at load: `mag = |u|`, with -32 saturating to 31. If `mag <= DEADBAND`, `mag = 0`. `sign = u[5]`.
- Prescaler: counter `pre` runs 0..PRESCALE-1 in RUN and DEAD. `tick` fires when `pre == PRESCALE-1`.
- Period counter `cnt` (5 bits): increments on `tick` and wraps 31 to 0. A boundary is a `tick` with `cnt == 31`, or entry into RUN.
- States:
  - IDLE: `pwm` = 0, `cnt` = 0, `pre` = 0.
  - RUN: `pwm = (cnt < duty)`.
  - DEAD: `pwm` = 0. `cnt` counts ticks from 0.
- Transitions:
  - IDLE to RUN: on `ena` high. This is a boundary (load is performed).
  - RUN boundary load, same sign: if new `mag == 0` or `sign == dir`, set `duty = mag` and stay in RUN. `dir` does not change on a zero-magnitude load.
  - RUN boundary load, reversal: if new `mag != 0` and `sign != dir`, go to DEAD. `cnt` = 0, `duty` = 0, and the pending values are latched internally.
  - DEAD to RUN: when DEAD has counted `DEAD_T` ticks. Set `dir = sign`, `duty = mag` (both from the DEAD-entry latch), `cnt` = 0, assert `period_start`.
  - Any state to IDLE: `ena` low, one clk later. `duty` and `dir` keep their values.
- `pwm` is decoded only from the registered `state`, `cnt` and `duty`.

## Timing
- Reset values: `pwm` = 0, `dir` = 0, `duty` = 0, `period_start` = 0, `cnt` = 0, `pre` = 0, pending = 0, state IDLE. Asserting `rst` mid-pulse drops `pwm` asynchronously.
- Latency from `u_valid` to effect:
  - Next boundary; at most 32*PRESCALE clks.
  - Reversals add DEAD_T*PRESCALE clks.
- `u_valid` on a boundary clk: the boundary loads the previous pending value; the new value applies at the following boundary.
- `ena` falling on a boundary clk: IDLE wins and no load occurs.
- `ena` low during DEAD: abort to IDLE. `dir` stays at its old value.
- Duty 0 gives `pwm` constantly low. Duty 31 gives 31 high ticks out of 32; there is never a 100% duty.
- `period_start` is high for exactly one clk, in the cycle where `cnt` becomes 0 in RUN.

## Structure
- Shared package `pid_pkg` holds:
  - `DUTY_W = 5` and `U_W = 6`.
  - The state enum `pwm_state_t` {IDLE, RUN, DEAD}.
- Sub-module `tick_gen` (the `PRESCALE` counter with `clr` and `tick`), reusable by other sampled stages.
- Everything else lives in one always_ff process plus combinational conversion. Target size is about 150–250 lines.

## Test plan
All scenarios use PRESCALE=1, DEAD_T=2, DEADBAND=1.
- Reset mid-pulse: `u` = +20 running, assert `rst` while `pwm` = 1 -> `pwm`, `dir`, `duty` drop to 0 immediately. After release, `pwm` stays 0 until enabled.
- Steady positive: `ena` = 1, `u` = +16 valid -> from the next boundary, `duty` = 16, `dir` = 0, `pwm` high 16 clks of every 32, `period_start` every 32 clks.
- Reversal with saturation: from +16, apply `u` = -32 -> at the boundary, `pwm` is low for 2 clks, then `dir` = 1, `duty` = 31, and `pwm` is high 31 of 32 clks.
- Deadband: `u` = +1 and then -1 -> `duty` = 0, `pwm` never high, `dir` unchanged, no DEAD state entered.
- Last-write-wins and boundary collision: `u` = +8 then +20 mid-period -> only 20 is applied. `u_valid` with +4 on a boundary clk -> 20 is loaded and 4 is applied one period later.
- Enable drop: `ena` low during RUN and during DEAD -> IDLE with `pwm` = 0 one clk later. Re-enable -> `period_start` on the next clk and `cnt` restarts at 0.
